float_to_fixed_serial: RTL and testbench

Converts one custom-precision float sample (sign, 8-bit exponent with bias 127, `word_length_in-1` mantissa bits) into a signed two's-complement fixed-point word with rounding and saturation. It uses a one-bit-per-cycle shifter and a small state machine. It sits at the output end of the filter-section chain: the float results produced by the section datapath are drained through this block to fixed-point consumers (DAC / capture FIFO). Both sides use valid/ready handshakes.

---
 rtl/float_to_fixed_serial.sv | 167 ++++++++++++++++
 tb/tb_float_to_fixed_serial.sv | 175 +++++++++++++++++
 2 files changed

// File: rtl/float_to_fixed_serial.sv
// Float {s, e[7:0], m} to signed fixed-point converter.
// A bit-serial shifter normalises the mantissa, then the result is rounded and saturated.
module float_to_fixed_serial #(
  parameter int word_length_in = 16,
  parameter int out_width      = 24,
  parameter int frac_bits      = 12
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic [word_length_in+7:0]   in_data,
  input  logic                        in_valid,
  output logic                        in_ready,
  output logic [out_width-1:0]        out_data,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic                        out_sat
);

  localparam int M  = word_length_in - 1;
  localparam int W  = word_length_in + 8;
  localparam int CW = $clog2(out_width + word_length_in + 2);

  localparam logic signed [15:0] KOFF = 16'(frac_bits - M - 127);
  localparam logic signed [15:0] LMAX = 16'(out_width - 1 - M);
  localparam logic        [15:0] RMAX = 16'(M + 1);

  localparam logic [out_width-1:0] POS_MAX =
    {1'b0, {(out_width-1){1'b1}}};
  localparam logic [out_width-1:0] NEG_MIN =
    {1'b1, {(out_width-1){1'b0}}};

  typedef enum logic [1:0] {
    S_IDLE,
    S_SHIFT,
    S_ROUND,
    S_HOLD
  } state_t;

  state_t r_state;
  state_t w_next;

  logic [out_width-1:0] r_mag;
  logic [CW-1:0]        r_cnt;
  logic                 r_left;
  logic                 r_rbit;
  logic                 r_sign;
  logic                 r_sat;
  logic [out_width-1:0] r_out_data;
  logic                 r_out_sat;

  logic                 w_s;
  logic [7:0]           w_e;
  logic [M-1:0]         w_m;
  logic signed [15:0]   w_k;
  logic                 w_kneg;
  logic [15:0]          w_kabs;
  logic                 w_zero;
  logic                 w_sat;
  logic [CW-1:0]        w_n;
  logic                 w_accept;
  logic [out_width-1:0] w_rnd;
  logic [out_width-1:0] w_res;

  assign w_s    = in_data[W-1];
  assign w_e    = in_data[W-2 -: 8];
  assign w_m    = in_data[M-1:0];
  assign w_k    = $signed({8'd0, w_e}) + KOFF;
  assign w_kneg = w_k[15];
  assign w_kabs = w_kneg ? 16'(-w_k) : 16'(w_k);

  // Exact -2^(out_width-1) is the one value at the top exponent that fits.
  always_comb begin
    w_zero = 1'b0;
    w_sat  = 1'b0;
    if (w_e == 8'd0) begin
      w_zero = 1'b1;
    end else if (w_e == 8'hFF) begin
      w_sat = 1'b1;
    end else if (!w_kneg && (w_k > LMAX)) begin
      w_sat = 1'b1;
    end else if (!w_kneg && (w_k == LMAX)) begin
      w_sat = !(w_s && (w_m == '0));
    end else if (w_kneg && (w_kabs > RMAX)) begin
      w_zero = 1'b1;
    end
  end

  assign w_n      = (w_zero || w_sat) ? '0 : w_kabs[CW-1:0];
  assign w_accept = in_valid && (r_state == S_IDLE);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_IDLE: begin
        if (in_valid) begin
          w_next = (w_n != '0) ? S_SHIFT : S_ROUND;
        end
      end
      S_SHIFT: begin
        if (r_cnt == CW'(1)) w_next = S_ROUND;
      end
      S_ROUND: w_next = S_HOLD;
      S_HOLD: begin
        if (out_ready) w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  assign w_rnd = r_mag + {{(out_width-1){1'b0}}, r_rbit};

  always_comb begin
    w_res = w_rnd;
    if (r_sat)       w_res = r_sign ? NEG_MIN : POS_MAX;
    else if (r_sign) w_res = -w_rnd;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_mag      <= '0;
      r_cnt      <= '0;
      r_left     <= 1'b0;
      r_rbit     <= 1'b0;
      r_sign     <= 1'b0;
      r_sat      <= 1'b0;
      r_out_data <= '0;
      r_out_sat  <= 1'b0;
    end else begin
      if (w_accept) begin
        r_sign <= w_s;
        r_sat  <= w_sat;
        r_left <= !w_kneg;
        r_rbit <= 1'b0;
        r_cnt  <= w_n;
        if (w_zero || w_sat) begin
          r_mag <= '0;
        end else begin
          r_mag <= {{(out_width-word_length_in){1'b0}}, 1'b1, w_m};
        end
      end
      if (r_state == S_SHIFT) begin
        r_cnt <= r_cnt - CW'(1);
        if (r_left) begin
          r_mag <= r_mag << 1;
        end else begin
          r_mag  <= r_mag >> 1;
          r_rbit <= r_mag[0];
        end
      end
      if (r_state == S_ROUND) begin
        r_out_data <= w_res;
        r_out_sat  <= r_sat;
      end
    end
  end

  assign in_ready  = (r_state == S_IDLE);
  assign out_valid = (r_state == S_HOLD);
  assign out_data  = r_out_data;
  assign out_sat   = r_out_sat;

endmodule

// File: tb/tb_float_to_fixed_serial.sv
// Directed bench for float_to_fixed_serial (M=15, 24-bit out, 12 frac bits).
// Expected words and latencies are hand-computed per vector.
module tb_float_to_fixed_serial;

  logic        clk;
  logic        reset;
  logic [23:0] in_data;
  logic        in_valid;
  logic        in_ready;
  logic [23:0] out_data;
  logic        out_valid;
  logic        out_ready;
  logic        out_sat;

  int checks;
  int errors;

  float_to_fixed_serial #(
    .word_length_in(16),
    .out_width(24),
    .frac_bits(12)
  ) dut (
    .clk(clk),
    .reset(reset),
    .in_data(in_data),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .out_data(out_data),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_sat(out_sat)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic wait_valid(output int lat);
    lat = 0;
    while (!out_valid && lat < 100) begin
      @(posedge clk);
      #1;
      lat++;
    end
  endtask

  task automatic release_out(input string tag);
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    chk({tag, "_vld_drop"}, 32'(out_valid), 32'd0);
    chk({tag, "_rdy_back"}, 32'(in_ready), 32'd1);
  endtask

  task automatic convert(input string tag,
                         input logic [23:0] d,
                         input logic [23:0] exp_d,
                         input logic exp_s,
                         input int exp_lat);
    int lat;
    @(negedge clk);
    in_data  = d;
    in_valid = 1'b1;
    chk({tag, "_in_ready"}, 32'(in_ready), 32'd1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_data  = ~d;
    wait_valid(lat);
    chk({tag, "_lat"}, 32'(lat), 32'(exp_lat));
    chk({tag, "_data"}, 32'(out_data), 32'(exp_d));
    chk({tag, "_sat"}, 32'(out_sat), 32'(exp_s));
    chk({tag, "_busy"}, 32'(in_ready), 32'd0);
    release_out(tag);
  endtask

  initial begin
    int lat;
    checks    = 0;
    errors    = 0;
    reset     = 1'b1;
    in_data   = '0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    #1;
    chk("rst_data", 32'(out_data), 32'd0);
    chk("rst_valid", 32'(out_valid), 32'd0);
    chk("rst_sat", 32'(out_sat), 32'd0);
    chk("rst_ready", 32'(in_ready), 32'd1);
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;

    convert("one",      24'h3F8000, 24'h001000, 1'b0, 4);
    convert("neg1p5",   24'hBFC000, 24'hFFE800, 1'b0, 4);
    convert("p256",     24'h438000, 24'h100000, 1'b0, 6);
    convert("p2m13",    24'h390000, 24'h000001, 1'b0, 17);
    convert("e113",     24'h388000, 24'h000000, 1'b0, 1);
    convert("half_up",  24'h39C000, 24'h000002, 1'b0, 16);
    convert("half_dn",  24'hB9C000, 24'hFFFFFE, 1'b0, 16);
    convert("e0",       24'h001234, 24'h000000, 1'b0, 1);
    convert("min_ex",   24'hC50000, 24'h800000, 1'b0, 9);
    convert("max_sat",  24'h450000, 24'h7FFFFF, 1'b1, 1);
    convert("ninf",     24'hFF8000, 24'h800000, 1'b1, 1);
    convert("e140",     24'h460000, 24'h7FFFFF, 1'b1, 1);

    // Reset while shifting, with a saturated result still on the output.
    @(negedge clk);
    in_data  = 24'h3F8000;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    @(posedge clk);
    #1;
    reset = 1'b1;
    #1;
    chk("mid_rst_valid", 32'(out_valid), 32'd0);
    chk("mid_rst_data", 32'(out_data), 32'd0);
    chk("mid_rst_sat", 32'(out_sat), 32'd0);
    chk("mid_rst_ready", 32'(in_ready), 32'd1);
    @(negedge clk);
    reset = 1'b0;
    convert("after_rst", 24'h3F8000, 24'h001000, 1'b0, 4);

    // Backpressure with a second sample already waiting on in_valid.
    @(negedge clk);
    in_data  = 24'h3F8000;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_data = 24'h438000;
    wait_valid(lat);
    chk("bp_lat", 32'(lat), 32'd4);
    chk("bp_data0", 32'(out_data), 32'h001000);
    for (int i = 0; i < 10; i++) begin
      @(posedge clk);
      #1;
      chk("bp_hold_data", 32'(out_data), 32'h001000);
      chk("bp_hold_vld", 32'(out_valid), 32'd1);
      chk("bp_hold_rdy", 32'(in_ready), 32'd0);
    end
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    chk("bp_idle_rdy", 32'(in_ready), 32'd1);
    chk("bp_idle_vld", 32'(out_valid), 32'd0);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    chk("bp_accepted", 32'(in_ready), 32'd0);
    wait_valid(lat);
    chk("bp2_lat", 32'(lat), 32'd6);
    chk("bp2_data", 32'(out_data), 32'h100000);
    chk("bp2_sat", 32'(out_sat), 32'd0);
    release_out("bp2");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
